// File: rtl/fp_pkg.sv
// Shared definitions for floating-point result stages: class encodings, field
// widths derived from the operand width, sticky-flag bit positions.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_NORMAL    = 3'd0,
    FP_ZERO      = 3'd1,
    FP_SUBNORMAL = 3'd2,
    FP_INF       = 3'd3,
    FP_NAN       = 3'd4
  } fp_class_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SUB  = 1;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_NAN  = 3;

  // Binary64 uses an 11-bit exponent; every other legal width is binary32.
  function automatic int exp_w(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int man_w(input int n);
    return n - 1 - exp_w(n);
  endfunction

  function automatic logic [3:0] class_flag(input fp_class_e c);
    logic [3:0] f;
    f = 4'b0000;
    case (c)
      FP_ZERO:      f[FLAG_ZERO] = 1'b1;
      FP_SUBNORMAL: f[FLAG_SUB]  = 1'b1;
      FP_INF:       f[FLAG_INF]  = 1'b1;
      FP_NAN:       f[FLAG_NAN]  = 1'b1;
      default:      f = 4'b0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 pattern classifier: N-bit packed value -> 3-bit class.
// Sign is irrelevant to the class.
module fp_classify
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] pat,
  output fp_class_e    cls
);

  localparam int E = exp_w(N);
  localparam int M = man_w(N);

  logic [E-1:0] exp_f;
  logic [M-1:0] man_f;
  logic         unused_sign;

  assign exp_f       = pat[N-2:M];
  assign man_f       = pat[M-1:0];
  assign unused_sign = pat[N-1];

  always_comb begin
    cls = FP_NORMAL;
    if (exp_f == '1) begin
      cls = (man_f != '0) ? FP_NAN : FP_INF;
    end else if (exp_f == '0) begin
      cls = (man_f != '0) ? FP_SUBNORMAL : FP_ZERO;
    end
  end

endmodule

// File: rtl/fp_mul_result_stage.sv
// Registered multiplier output stage: classify, sticky flags, 2-entry skid buffer.
// Define FP_RES_CNT_EN to add saturating NaN/inf event counters.
module fp_mul_result_stage
  import fp_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [2:0]   out_class,
  output logic [3:0]   flags,
  input  logic         flag_clr,
  output buf_state_e   dbg_state
`ifdef FP_RES_CNT_EN
  ,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] inf_cnt
`endif
);

  // Handshake: a beat moves on a rising edge where valid && ready on that side.
  // in_ready depends only on the registered buffer state, so the multiplier's
  // combinational path never sees out_ready.

  buf_state_e   state_q, state_d;
  logic [N-1:0] main_data_q, main_data_d;
  logic [N-1:0] skid_data_q, skid_data_d;
  fp_class_e    main_class_q, main_class_d;
  fp_class_e    skid_class_q, skid_class_d;
  logic [3:0]   flags_q, flags_d;
  fp_class_e    in_class;
  logic         accept;
  logic         pop;

  fp_classify #(.N(N)) u_classify (
    .pat (in_result),
    .cls (in_class)
  );

  assign in_ready   = (state_q != BUF_FULL);
  assign out_valid  = (state_q != BUF_EMPTY);
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = main_data_q;
  assign out_class  = main_class_q;
  assign flags      = flags_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_class_d = main_class_q;
    skid_data_d  = skid_data_q;
    skid_class_d = skid_class_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_data_d  = in_result;
          main_class_d = in_class;
          state_d      = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && pop) begin
          main_data_d  = in_result;
          main_class_d = in_class;
        end else if (accept) begin
          skid_data_d  = in_result;
          skid_class_d = in_class;
          state_d      = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          main_data_d  = skid_data_q;
          main_class_d = skid_class_q;
          state_d      = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // A clear coinciding with an accept keeps only the new event's flag.
  always_comb begin
    flags_d = flag_clr ? 4'b0000 : flags_q;
    if (accept) begin
      flags_d = flags_d | class_flag(in_class);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      main_data_q  <= '0;
      main_class_q <= FP_NORMAL;
      skid_data_q  <= '0;
      skid_class_q <= FP_NORMAL;
      flags_q      <= 4'b0000;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_class_q <= main_class_d;
      skid_data_q  <= skid_data_d;
      skid_class_q <= skid_class_d;
      flags_q      <= flags_d;
    end
  end

`ifdef FP_RES_CNT_EN
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;

  // Clear first, then count the coincident event; counters stick at all-ones.
  always_comb begin
    nan_cnt_d = flag_clr ? '0 : nan_cnt_q;
    inf_cnt_d = flag_clr ? '0 : inf_cnt_q;
    if (accept && (in_class == FP_NAN) && !(&nan_cnt_d)) begin
      nan_cnt_d = nan_cnt_d + 1'b1;
    end
    if (accept && (in_class == FP_INF) && !(&inf_cnt_d)) begin
      inf_cnt_d = inf_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt_q <= '0;
      inf_cnt_q <= '0;
    end else begin
      nan_cnt_q <= nan_cnt_d;
      inf_cnt_q <= inf_cnt_d;
    end
  end

  assign nan_cnt = nan_cnt_q;
  assign inf_cnt = inf_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Scoreboard bench for fp_mul_result_stage: directed vectors, backpressure,
// random handshake toggling, reset while full, binary64 instance.
module tb_fp_mul_result_stage;
  import fp_pkg::*;

  localparam int N     = 32;
  localparam int CNT_W = 2;
  localparam int W     = N + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic [N-1:0] in_result, out_result;
  logic [2:0]   out_class;
  logic [3:0]   flags;
  buf_state_e   dbg_state;

  logic         in_valid64, in_ready64, out_valid64;
  logic [63:0]  in_result64, out_result64;
  logic [2:0]   out_class64;
  logic [3:0]   flags64;
  buf_state_e   dbg_state64;

`ifdef FP_RES_CNT_EN
  logic [CNT_W-1:0] nan_cnt, inf_cnt, nan_cnt64, inf_cnt64;
`endif

  fp_mul_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_class  (out_class),
    .flags      (flags),
    .flag_clr   (flag_clr),
    .dbg_state  (dbg_state)
`ifdef FP_RES_CNT_EN
    ,
    .nan_cnt    (nan_cnt),
    .inf_cnt    (inf_cnt)
`endif
  );

  fp_mul_result_stage #(.N(64), .CNT_W(CNT_W)) dut64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid64),
    .in_ready   (in_ready64),
    .in_result  (in_result64),
    .out_valid  (out_valid64),
    .out_ready  (1'b1),
    .out_result (out_result64),
    .out_class  (out_class64),
    .flags      (flags64),
    .flag_clr   (1'b0),
    .dbg_state  (dbg_state64)
`ifdef FP_RES_CNT_EN
    ,
    .nan_cnt    (nan_cnt64),
    .inf_cnt    (inf_cnt64)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic         rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", {out_class, out_result});
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_beat", 64'({out_class, out_result}), 64'(mon_exp));
        pops++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] d, input logic [2:0] c);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_result = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({c, d});
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_ready required=ready");
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic gen(output logic [N-1:0] d, output logic [2:0] c);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    c = 3'($urandom_range(0, 4));
    m = 23'($urandom_range(1, 23'h7FFFFF));
    case (c)
      3'd0: begin e = 8'($urandom_range(1, 254)); m = 23'($urandom); end
      3'd1: begin e = 8'h00; m = 23'h0; end
      3'd2: e = 8'h00;
      3'd3: begin e = 8'hFF; m = 23'h0; end
      default: e = 8'hFF;
    endcase
    d = {s, e, m};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pops_before;
    int acc;
    int cyc;
    logic pushed;
    logic [N-1:0] rd;
    logic [2:0]   rc;

    in_valid = 1'b0; in_result = '0; out_ready = 1'b0; flag_clr = 1'b0;
    in_valid64 = 1'b0; in_result64 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(BUF_EMPTY));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Five classes back-to-back
    out_ready = 1'b1;
    send(32'h3F800000, 3'd0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    send(32'h80000000, 3'd1);
    send(32'h00000001, 3'd2);
    send(32'h7F800000, 3'd3);
    send(32'h7FC00000, 3'd4);
    check("flags_all", 64'(flags), 64'hF);
    drain();

    // Flag clear, then clear coincident with accept
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    check("flags_cleared", 64'(flags), 64'h0);
    send(32'h7FC00000, 3'd4);
    check("flags_nan", 64'(flags), 64'h8);
    flag_clr = 1'b1;
    send(32'hFF800000, 3'd3);
    flag_clr = 1'b0;
    check("flags_clr_set", 64'(flags), 64'h4);
    drain();

    // Backpressure fills both entries
    out_ready = 1'b0;
    send(32'h40000000, 3'd0);
    send(32'h40400000, 3'd0);
    in_valid  = 1'b1;
    in_result = 32'h40800000;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      check("full_hold_data", 64'(out_result), 64'h40000000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h40800000, 3'd0);
    drain();

`ifdef FP_RES_CNT_EN
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'h7FC00000 | 32'(i), 3'd4);
      check("nan_cnt_sat", 64'(nan_cnt), 64'((i < 2) ? i + 1 : 3));
    end
    check("inf_cnt_zero", 64'(inf_cnt), 64'd0);
    flag_clr = 1'b1;
    send(32'h7F800000, 3'd3);
    flag_clr = 1'b0;
    check("inf_cnt_clr_inc", 64'(inf_cnt), 64'd1);
    check("nan_cnt_clr", 64'(nan_cnt), 64'd0);
    drain();
`endif

    // Random handshake toggling
    acc = 0;
    cyc = 0;
    pushed = 1'b0;
    rand_mode = 1'b1;
    while (acc < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        gen(rd, rc);
        in_valid  = 1'b1;
        in_result = rd;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      pushed = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back({rc, rd});
        acc++;
        pushed = 1'b1;
      end
      cyc++;
    end
    if (!pushed) in_valid = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    rand_mode = 1'b0;
    check("rand_accepted", 64'(acc), 64'd1000);
    drain();

    // Reset while FULL
    out_ready = 1'b0;
    send(32'h7F800000, 3'd3);
    send(32'h00000000, 3'd1);
    check("prereset_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_flags", 64'(flags), 64'd0);
    check("arst_out_result", 64'(out_result), 64'd0);
    exp_q.delete();
    pops_before = pops;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h3F800000, 3'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_single", 64'(pops - pops_before), 64'd1);

    // Binary64 classification
    in_valid64  = 1'b1;
    in_result64 = 64'h7FF8000000000000;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    check("n64_valid", 64'(out_valid64), 64'd1);
    check("n64_nan_class", 64'(out_class64), 64'd4);
    check("n64_nan_data", out_result64, 64'h7FF8000000000000);
    in_valid64  = 1'b1;
    in_result64 = 64'h0000000000000001;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    check("n64_sub_class", 64'(out_class64), 64'd2);
    in_valid64  = 1'b1;
    in_result64 = 64'h0010000000000000;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    check("n64_norm_class", 64'(out_class64), 64'd0);
    check("n64_flags", 64'(flags64), 64'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
